// File: rtl/mod_mixer.sv
// Two-oscillator modulation stage for the DDS path.
// Combines osc0/osc1 into one OW-bit sample; AM runs on a shift-add multiplier.
`timescale 1ns/1ps

module mod_mixer #(
    parameter int W  = 12,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_en,
    input  logic [W-1:0]  osc0,
    input  logic [W-1:0]  osc1,
    input  logic [2:0]    mod_sel,
    output logic [OW-1:0] mod_out,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] modeSum  = 3'b000;
    localparam logic [2:0] modeAm   = 3'b001;
    localparam logic [2:0] modeXor  = 3'b010;
    localparam logic [2:0] modeDiff = 3'b011;
    localparam logic [2:0] modePass = 3'b100;
    localparam logic [2:0] modeRing = 3'b101;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state;
    state_t stateNext;

    logic [W-1:0]   opA;
    logic [W-1:0]   opB;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] partial;
    logic [2*W-1:0] accNext;
    logic [CW-1:0]  cnt;
    logic           lastStep;
    logic           accept;

    logic [W:0]     sumFull;
    logic [W-1:0]   absDiff;
    logic [W-1:0]   ringVal;
    logic [OW-1:0]  directResult;

    assign accept   = sample_en && (state == IDLE);
    assign lastStep = (cnt == CW'(W - 1));

    // Non-AM result straight from the inputs; only used on the accept edge,
    // so the mode and operands are effectively latched with the result.
    always_comb begin
        sumFull      = {1'b0, osc0} + {1'b0, osc1};
        absDiff      = (osc0 >= osc1) ? (osc0 - osc1) : (osc1 - osc0);
        ringVal      = osc0 ^ {W{osc1[W-1]}};
        directResult = '0;
        case (mod_sel)
            modeSum:  directResult = OW'(sumFull) << (OW - W - 1);
            modeXor:  directResult = OW'(osc0 ^ osc1) << (OW - W);
            modeDiff: directResult = OW'(absDiff) << (OW - W);
            modePass: directResult = OW'(osc0) << (OW - W);
            modeRing: directResult = OW'(ringVal) << (OW - W);
            default:  directResult = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set.
    always_comb begin
        partial = '0;
        if (opB[cnt]) begin
            partial = {{W{1'b0}}, opA} << cnt;
        end
        accNext = acc + partial;
    end

    // State register for the multiply sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and busy decode: MUL lasts exactly W cycles.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (sample_en && (mod_sel == modeAm)) begin
                    stateNext = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (lastStep) begin
                    stateNext = IDLE;
                end
            end
        endcase
    end

    // Operand capture, multiply accumulation and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opA       <= '0;
            opB       <= '0;
            acc       <= '0;
            cnt       <= '0;
            mod_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            if (accept) begin
                opA <= osc0;
                opB <= osc1;
                acc <= '0;
                cnt <= '0;
                if (mod_sel != modeAm) begin
                    mod_out   <= directResult;
                    out_valid <= 1'b1;
                end
            end else if (state == MUL) begin
                acc <= accNext;
                cnt <= cnt + CW'(1);
                if (sample_en) begin
                    overrun <= 1'b1;
                end
                if (lastStep) begin
                    mod_out   <= accNext[2*W-1 -: OW];
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_mixer.sv
// Self-checking bench for mod_mixer (W=12, OW=16).
// Vector table plus scoreboard; hand sequences for overrun, reset and mode latch.
`timescale 1ns/1ps

module tb_mod_mixer;

    localparam int W  = 12;
    localparam int OW = 16;
    localparam int NV = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_en;
    logic [W-1:0]  osc0;
    logic [W-1:0]  osc1;
    logic [2:0]    mod_sel;
    logic [OW-1:0] mod_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2:0]    sel;
        logic [OW-1:0] exp;
        string         nm;
    } vec_t;

    vec_t          vecs[NV];
    logic [OW-1:0] expQ[$];
    string         nameQ[$];
    string         monName;
    int            nChecks = 0;
    int            nPass = 0;

    mod_mixer #(.W(W), .OW(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .osc0      (osc0),
        .osc1      (osc1),
        .mod_sel   (mod_sel),
        .mod_out   (mod_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [2:0] sel);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic [W-1:0]   d;
        s = {1'b0, a} + {1'b0, b};
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        d = (a > b) ? (a - b) : (b - a);
        case (sel)
            3'b000:  model = {s, 3'b000};
            3'b001:  model = p[23:8];
            3'b010:  model = {a ^ b, 4'h0};
            3'b011:  model = {d, 4'h0};
            3'b100:  model = {a, 4'h0};
            3'b101:  model = {a ^ {W{b[W-1]}}, 4'h0};
            default: model = '0;
        endcase
    endfunction

    // Scoreboard: every out_valid pops one expected sample.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                monName = nameQ.pop_front();
                check(monName, 32'(mod_out), 32'(expQ.pop_front()));
            end
        end
    end

    task automatic waitValid(output int lat, output int busyCnt);
        lat = 0;
        busyCnt = busy ? 1 : 0;
        while (!out_valid && lat < W + 4) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busyCnt++;
        end
    endtask

    task automatic runVec(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] sel, input logic [OW-1:0] exp,
                          input string nm);
        int lat;
        int busyCnt;
        osc0      = a;
        osc1      = b;
        mod_sel   = sel;
        sample_en = 1'b1;
        expQ.push_back(exp);
        nameQ.push_back(nm);
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        waitValid(lat, busyCnt);
        check({nm, "_latency"}, 32'(lat), (sel == 3'b001) ? 32'(W) : 32'd0);
        check({nm, "_busy"}, 32'(busyCnt), (sel == 3'b001) ? 32'(W) : 32'd0);
    endtask

    initial begin
        int lat;
        int busyCnt;
        int seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rs;

        vecs[0]  = '{12'hFFF, 12'h001, 3'b000, 16'h8000, "sum_carry"};
        vecs[1]  = '{12'h800, 12'h800, 3'b001, 16'h4000, "am_half"};
        vecs[2]  = '{12'hAAA, 12'h555, 3'b010, 16'hFFF0, "xor"};
        vecs[3]  = '{12'h100, 12'h300, 3'b011, 16'h2000, "diff_neg"};
        vecs[4]  = '{12'h300, 12'h100, 3'b011, 16'h2000, "diff_pos"};
        vecs[5]  = '{12'hABC, 12'h123, 3'b100, 16'hABC0, "pass0"};
        vecs[6]  = '{12'h123, 12'h800, 3'b101, 16'hEDC0, "ring_inv"};
        vecs[7]  = '{12'h123, 12'h7FF, 3'b101, 16'h1230, "ring_pass"};
        vecs[8]  = '{12'h5A5, 12'hA5A, 3'b110, 16'h0000, "mode110"};
        vecs[9]  = '{12'h5A5, 12'hA5A, 3'b111, 16'h0000, "mode111"};
        vecs[10] = '{12'hFFF, 12'hFFF, 3'b001, 16'hFFE0, "am_max"};
        vecs[11] = '{12'h000, 12'h000, 3'b000, 16'h0000, "sum_zero"};
        vecs[12] = '{12'h800, 12'h800, 3'b000, 16'h8000, "sum_msb"};
        vecs[13] = '{12'h123, 12'h456, 3'b001, 16'h04ED, "am_mixed"};
        vecs[14] = '{12'h000, 12'hFFF, 3'b001, 16'h0000, "am_zero"};
        vecs[15] = '{12'h7FF, 12'h001, 3'b000, 16'h4000, "sum_mid"};

        rst_n     = 1'b0;
        sample_en = 1'b0;
        osc0      = '0;
        osc1      = '0;
        mod_sel   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mod_out", 32'(mod_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            runVec(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, vecs[i].nm);
        end

        repeat (5) @(posedge clk);
        #1;
        check("hold_mod_out", 32'(mod_out), 32'(vecs[NV-1].exp));
        check("hold_no_valid", 32'(out_valid), 32'd0);

        // Overrun: second strobe three cycles into an AM is dropped.
        osc0      = 12'h800;
        osc1      = 12'h800;
        mod_sel   = 3'b001;
        sample_en = 1'b1;
        expQ.push_back(16'h4000);
        nameQ.push_back("ovr_am");
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        osc0      = 12'hFFF;
        osc1      = 12'h001;
        mod_sel   = 3'b000;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        check("ovr_pulse", 32'(overrun), 32'd1);
        @(posedge clk);
        #1;
        check("ovr_clear", 32'(overrun), 32'd0);
        waitValid(lat, busyCnt);
        check("ovr_am_done", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("ovr_single_pulse", 32'(out_valid), 32'd0);
        check("ovr_hold", 32'(mod_out), 32'h4000);

        // Reset five cycles into an AM aborts it silently.
        osc0      = 12'hFFF;
        osc1      = 12'hFFF;
        mod_sel   = 3'b001;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mod_out", 32'(mod_out), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check("midrst_quiet", 32'(seen), 32'd0);
        runVec(12'h7FF, 12'h001, 3'b000, 16'h4000, "post_rst_sum");

        // Mode and operands changed mid-multiply do not affect the result.
        osc0      = 12'h123;
        osc1      = 12'h456;
        mod_sel   = 3'b001;
        sample_en = 1'b1;
        expQ.push_back(16'h04ED);
        nameQ.push_back("latch_am");
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        @(posedge clk);
        #1;
        mod_sel = 3'b010;
        osc0    = 12'hAAA;
        osc1    = 12'h555;
        waitValid(lat, busyCnt);
        check("latch_am_latency", 32'(lat), 32'(W - 1));
        runVec(12'hAAA, 12'h555, 3'b010, 16'hFFF0, "latch_next_xor");

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom_range(0, 4095));
            rb = W'($urandom_range(0, 4095));
            rs = 3'($urandom_range(0, 7));
            runVec(ra, rb, rs, model(ra, rb, rs), "rand");
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
